// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and standard FIFO depths for the QSPI controller
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int TX_FIFO_ADDR_WIDTH = 4;
    localparam int RX_FIFO_ADDR_WIDTH = 4;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one registered read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // storage is deliberately left unreset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock FIFO with wrap-bit pointers, full/empty flags and fill count
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic wr_accept, rd_accept;

    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0] && wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH];
    assign count = wr_ptr - rd_ptr;
    assign rd_accept = rd_en & ~empty;
    // a write into a full FIFO is fine when the oldest slot is being read out on the same edge
    assign wr_accept = wr_en & (~full | rd_accept);

    always_ff @(posedge clk)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk(clk),
        .reset(reset),
        .we(wr_accept),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .re(rd_accept),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(data_out)
    );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for a 4-entry fifo
module tb_fifo;
    logic        clk = 0;
    logic        reset = 0;
    logic        wr_en = 0;
    logic        rd_en = 0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        full, empty;
    logic [2:0]  count;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .data_in(data_in),
        .full(full),
        .rd_en(rd_en),
        .data_out(data_out),
        .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] d);
        reset = r;
        wr_en = w;
        rd_en = rd;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_dout", data_out, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, i);
            check("fill_count", 32'(count), i + 1);
        end
        check("fill_full", 32'(full), 1);
        check("fill_empty", 32'(empty), 0);
        step(1, 1, 0, 32'hDEAD);
        check("ovf_count", 32'(count), 4);
        check("ovf_full", 32'(full), 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0);
            check("drain_dout", data_out, i);
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
        step(1, 0, 1, 0);
        check("udf_empty", 32'(empty), 1);
        check("udf_count", 32'(count), 0);
        check("udf_dout", data_out, 3);
        step(1, 1, 1, 32'd100);
        check("sim_empty_count", 32'(count), 1);
        check("sim_empty_dout", data_out, 3);
        step(1, 1, 0, 32'd101);
        exp_q = '{32'd100, 32'd101};
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 102 + i);
            exp = exp_q.pop_front();
            exp_q.push_back(102 + i);
            check("sim_dout", data_out, exp);
            check("sim_count", 32'(count), 2);
        end
        step(1, 1, 0, 32'd200);
        step(1, 1, 0, 32'd201);
        exp_q.push_back(200);
        exp_q.push_back(201);
        check("refill_full", 32'(full), 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 300 + i);
            exp = exp_q.pop_front();
            exp_q.push_back(300 + i);
            check("simf_dout", data_out, exp);
            check("simf_count", 32'(count), 4);
            check("simf_full", 32'(full), 1);
        end
        step(0, 1, 1, 32'h55);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_dout", data_out, 0);
        step(1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
